// File: rtl/afe_config_sequencer.sv
// Command-ROM driven configuration sequencer for an AFE serial port:
// fetches opcodes, shifts 20-bit words out MSB first, and times waits/AFE resets.
module afe_config_sequencer #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [7:0]  rom_address,
  input  logic [3:0]  rom_command,
  input  logic [19:0] rom_data,
  output logic        afe_sclk,
  output logic        afe_sen_n,
  output logic        afe_sdata,
  output logic        afe_reset_n,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SHIFT,
    S_GAP,
    S_WAIT,
    S_ARST,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [19:0] shreg_q, shreg_d;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        sclk_q, sclk_d;
  logic        sen_n_q, sen_n_d;
  logic        sdata_q, sdata_d;
  logic        arst_n_q, arst_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        advance;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    sdata_d   = sdata_q;
    advance   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          pc_d    = 8'd0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (rom_command)
          4'h0: advance = 1'b1;
          4'h1: begin
            shreg_d   = rom_data;
            sdata_d   = rom_data[19];
            sclk_d    = 1'b0;
            div_cnt_d = 8'd0;
            bit_cnt_d = 5'd0;
            state_d   = S_SHIFT;
          end
          4'h2: begin
            cnt_d   = rom_data;
            state_d = S_WAIT;
          end
          4'h3: begin
            cnt_d   = rom_data;
            state_d = S_ARST;
          end
          4'hF:    state_d = S_DONE;
          default: state_d = S_ERROR;
        endcase
      end
      S_SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = 8'd0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_cnt_q == 5'd19) begin
            state_d = S_GAP;
          end else begin
            // Next bit is presented on the falling edge, stable for the whole high phase.
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q + 5'd1;
            shreg_d   = {shreg_q[18:0], 1'b0};
            sdata_d   = shreg_q[18];
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = 8'd0;
          advance   = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      S_WAIT, S_ARST: begin
        // An operand of 0 or 1 both spend a single cycle here.
        if (cnt_q <= 20'd1) begin
          cnt_d   = 20'd0;
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (pc_q == 8'hFF) begin
        state_d = S_ERROR;
      end else begin
        pc_d    = pc_q + 8'd1;
        state_d = S_FETCH;
      end
    end

    // AFE pins are only ever non-idle while shifting or holding the AFE in reset.
    sen_n_d  = (state_d != S_SHIFT);
    arst_n_d = (state_d != S_ARST);
    if (state_d != S_SHIFT) begin
      sclk_d  = 1'b0;
      sdata_d = 1'b0;
    end
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERROR);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pc_q      <= 8'd0;
      shreg_q   <= 20'd0;
      cnt_q     <= 20'd0;
      div_cnt_q <= 8'd0;
      bit_cnt_q <= 5'd0;
      sclk_q    <= 1'b0;
      sen_n_q   <= 1'b1;
      sdata_q   <= 1'b0;
      arst_n_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      sen_n_q   <= sen_n_d;
      sdata_q   <= sdata_d;
      arst_n_q  <= arst_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign rom_address = pc_q;
  assign afe_sclk    = sclk_q;
  assign afe_sen_n   = sen_n_q;
  assign afe_sdata   = sdata_q;
  assign afe_reset_n = arst_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule
